// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the default boot address, fetch buffer depth and address/instruction widths.
package inst_fetch_pkg;

  localparam int ADDR_W      = 32;
  localparam int INST_W      = 32;
  localparam int FETCH_DEPTH = 2;
  localparam int ENTRY_W     = ADDR_W + INST_W;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Clears the byte offset so every fetch target is word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~(ADDR_W'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of fetched {pc, inst} pairs between memory and decode.
// Flush empties it in one cycle; simultaneous push and pop keep the count unchanged.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DATA_W = ENTRY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] store_p0 [FETCH_DEPTH];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
      // Storage is cleared too so the decode-facing outputs read zero after reset.
      for (int i = 0; i < FETCH_DEPTH; i++) store_p0[i] <= '0;
    end else if (flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        store_p0[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign head_data = store_p0[rd_ptr];
  assign count     = count_q;
  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'(FETCH_DEPTH));

  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && empty));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word-aligned reads, buffers returned words with their pc,
// and discards responses that were in flight when a redirect arrived.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  logic [ADDR_W-1:0] req_pc_p0;
  logic [ADDR_W-1:0] resp_pc_p1;
  logic [1:0]        outstanding;
  logic [1:0]        drop_cnt;

  logic [ADDR_W-1:0] target_pc;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  fetch_entry_t      head_entry;
  fetch_entry_t      push_entry;
  logic              req_hs;
  logic              resp_hs;
  logic              resp_drop;
  logic              push;
  logic              pop;
  logic [2:0]        credit_used;

  assign target_pc = word_align(redirect_pc);

  assign if_valid = !rst && !fifo_empty && !redirect_valid;
  assign pop      = if_valid && if_ready;

  // Every in-flight request owns a buffer slot, so a response can always be stored.
  assign credit_used    = 3'(outstanding) + 3'(fifo_count) - 3'(pop);
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < 3'(FETCH_DEPTH));
  assign imem_req_addr  = req_pc_p0;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign resp_hs    = imem_resp_valid;
  assign resp_drop  = (drop_cnt != 2'd0) || redirect_valid;
  assign push       = resp_hs && !resp_drop && !rst;
  assign push_entry = '{pc: resp_pc_p1, inst: imem_resp_data};

  // ---- request stage (p0) / response stage (p1) bookkeeping ----
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_p0   <= RESET_PC;
      resp_pc_p1  <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding + 2'(req_hs) - 2'(resp_hs);
      if (redirect_valid) begin
        req_pc_p0  <= target_pc;
        resp_pc_p1 <= target_pc;
        // Everything still in flight belongs to the old path; a response
        // arriving now is discarded directly and is not counted again.
        drop_cnt   <= outstanding - 2'(resp_hs);
      end else begin
        if (req_hs) req_pc_p0 <= req_pc_p0 + ADDR_W'(4);
        if (resp_hs) begin
          if (drop_cnt != 2'd0) drop_cnt   <= drop_cnt - 2'd1;
          else                  resp_pc_p1 <= resp_pc_p1 + ADDR_W'(4);
        end
      end
    end
  end

  // ---- decode-facing buffer ----
  fetch_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign if_inst = head_entry.inst;
  assign if_pc   = head_entry.pc;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

  a_resp_has_request : assert property (@(posedge clk) disable iff (rst)
    !(resp_hs && (outstanding == 2'd0)));

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: behavioural memory with configurable latency,
// in-order expected-pc scoreboard, and a table of redirect scenarios.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    int          mode;  // 0: two in flight, no response; 1: with response; 2: back-to-back
  } redir_vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_pop  = 0;
  int          n_acc  = 0;
  int          cyc    = 0;
  int          lat    = 1;
  bit          rand_ready = 1'b0;
  mreq_t       mq[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_from(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 600; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Memory model: accepts at the edge, answers in order after lat cycles, reset by rst.
  initial begin
    logic        acc;
    logic        fired;
    logic        rst_s;
    logic [31:0] acc_addr;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc      = imem_req_valid & imem_req_ready;
      acc_addr = imem_req_addr;
      fired    = imem_resp_valid;
      rst_s    = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_s) begin
        mq.delete();
      end else begin
        if (fired && mq.size() > 0) void'(mq.pop_front());
        if (acc) begin
          mq.push_back('{addr: acc_addr, due: cyc + lat - 1});
          n_acc++;
        end
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
      imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard: every instruction handed to decode must be the next expected pc.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (if_valid && if_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h expected no instruction", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e);
          chk("if_inst", if_inst, mem_word(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "simulation timed out");
  end

  initial begin
    redir_vec_t vec[5];
    int         a0;
    int         p0;
    bit         found;

    vec[0] = '{target: 32'h0000_0100, exp_addr: 32'h0000_0100, mode: 0};
    vec[1] = '{target: 32'h0000_0203, exp_addr: 32'h0000_0200, mode: 1};
    vec[2] = '{target: 32'h0000_1001, exp_addr: 32'h0000_1000, mode: 0};
    vec[3] = '{target: 32'h8000_0006, exp_addr: 32'h8000_0004, mode: 1};
    vec[4] = '{target: 32'h0000_0040, exp_addr: 32'h0000_0040, mode: 2};

    rst            = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);

    // Streaming with single-cycle memory: one request per cycle.
    step();
    expect_from(RST_PC);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("reset_if_inst", if_inst, 32'h0);
        chk("reset_if_pc", if_pc, 32'h0);
      end
      chk("stream_req_addr", imem_req_addr, RST_PC + 32'(4 * i));
      chk("stream_req_valid", 32'(imem_req_valid), 32'd1);
      if (i >= 2) chk("stream_if_valid", 32'(if_valid), 32'd1);
      step();
    end
    repeat (20) step();
    chk("stream_progress", 32'(n_pop >= 20), 32'd1);

    // Decode stall straight out of reset: exactly two requests, buffer holds them.
    rst      = 1'b1;
    if_ready = 1'b0;
    repeat (2) step();
    expect_from(RST_PC);
    a0  = n_acc;
    rst = 1'b0;
    repeat (10) step();
    chk("stall_req_count", 32'(n_acc - a0), 32'd2);
    @(negedge clk);
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    chk("stall_if_pc", if_pc, RST_PC);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_req_addr", imem_req_addr, RST_PC + 32'd8);
    step();
    if_ready = 1'b1;
    p0 = n_pop;
    repeat (6) step();
    chk("release_progress", 32'(n_pop - p0 >= 4), 32'd1);

    // Fill the buffer again, then reset with it full.
    if_ready = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("full_if_valid", 32'(if_valid), 32'd1);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_full_if_valid", 32'(if_valid), 32'd0);
    chk("rst_full_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    expect_from(RST_PC);
    rst      = 1'b0;
    if_ready = 1'b1;
    @(negedge clk);
    chk("restart_req_addr", imem_req_addr, RST_PC);
    chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
    p0 = n_pop;
    repeat (10) step();
    chk("restart_progress", 32'(n_pop - p0 >= 5), 32'd1);

    // Redirect scenarios with a slower memory.
    lat = 3;
    for (int k = 0; k < 5; k++) begin
      found = (vec[k].mode == 2);
      for (int w = 0; w < 60 && !found; w++) begin
        step();
        if (vec[k].mode == 0) found = (mq.size() == 2) && !imem_resp_valid;
        else                  found = imem_resp_valid;
      end
      chk("redir_trigger", 32'(found), 32'd1);
      if (vec[k].mode == 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7000_0000;
        @(negedge clk);
        chk("b2b_first_if_valid", 32'(if_valid), 32'd0);
        step();
      end
      redirect_valid = 1'b1;
      redirect_pc    = vec[k].target;
      expect_from(vec[k].exp_addr);
      @(negedge clk);
      chk("redir_if_valid", 32'(if_valid), 32'd0);
      chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_req_addr", imem_req_addr, vec[k].exp_addr);
      p0 = n_pop;
      repeat (15) step();
      chk("redir_progress", 32'(n_pop - p0 >= 3), 32'd1);
    end

    // Random memory backpressure and decode stalls; stream must stay sequential.
    rand_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 300; i++) begin
      step();
      if_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random_progress", 32'(n_pop - p0 >= 30), 32'd1);
    rand_ready = 1'b0;
    if_ready   = 1'b1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
